// File: rtl/mem_stage_access_pkg.sv
// Shared types and defaults for the MEM stage: FSM state encoding,
// parameter defaults and the alignment decode used by the top level.
package mem_stage_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TIMEOUT_DEF = 16;

  // Word accesses only: any set bit in the byte offset is misaligned.
  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage

// File: rtl/mem_stage_access_if.sv
// Data-memory req/ack bus. The MEM stage is the master; the memory
// (or its model) is the slave.
interface mem_stage_access_if
  import mem_stage_access_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_access_timeout_ctr.sv
// Bus-timeout counter: cleared while no access is outstanding, counts
// BUSY cycles without ack, flags the last allowed cycle.
module mem_timeout_ctr
  import mem_stage_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear has priority over enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/mem_stage_access.sv
// MEM pipeline stage: consumes the EX/MEM bundle, performs loads/stores
// over the req/ack data bus, stalls the front of the pipe while an access
// is outstanding and registers the MEM/WB boundary.
module mem_stage_access
  import mem_stage_access_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MEM_RegWrite,
  input  logic              MEM_MemToReg,
  input  logic              MEM_MemWrite,
  input  logic [4:0]        MEM_WriteReg,
  input  logic [DATA_W-1:0] MEM_WriteData,
  input  logic [DATA_W-1:0] MEM_AluResult,
  input  logic [31:0]       MEM_PC,
  input  logic [31:0]       MEM_Instr,
  mem_stage_access_if.master dmem,
  output logic              mem_stall,
  output logic              WB_RegWrite,
  output logic [4:0]        WB_WriteReg,
  output logic [DATA_W-1:0] WB_Result,
  output logic [31:0]       WB_PC,
  output logic [31:0]       WB_Instr,
  output logic              align_err,
  output logic              bus_err
);

  state_t state_q, state_d;

  // Bus drive registers
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // Instruction bundle captured at launch, plus load data captured on ack
  logic              cap_rw_q, cap_rw_d;
  logic              cap_m2r_q, cap_m2r_d;
  logic [4:0]        cap_wreg_q, cap_wreg_d;
  logic [DATA_W-1:0] cap_alu_q, cap_alu_d;
  logic [31:0]       cap_pc_q, cap_pc_d;
  logic [31:0]       cap_instr_q, cap_instr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // MEM/WB boundary and error pulses
  logic              wb_rw_q, wb_rw_d;
  logic [4:0]        wb_wreg_q, wb_wreg_d;
  logic [DATA_W-1:0] wb_res_q, wb_res_d;
  logic [31:0]       wb_pc_q, wb_pc_d;
  logic [31:0]       wb_instr_q, wb_instr_d;
  logic              align_q, align_d;
  logic              berr_q, berr_d;

  logic access, misal, launch;
  logic ctr_clr, ctr_en, ctr_expire;

  mem_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (ctr_clr),
    .en_i     (ctr_en),
    .expire_o (ctr_expire)
  );

  // Access decode and stall; stall is forced low while reset is held.
  always_comb begin
    access    = MEM_MemToReg | MEM_MemWrite;
    misal     = is_misaligned(MEM_AluResult[1:0]);
    launch    = (state_q == ST_IDLE) && access && !misal;
    mem_stall = !reset && (launch || (state_q == ST_BUSY));
  end

  // Next-state and datapath decode for the IDLE -> BUSY -> DONE sequence.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cap_rw_d    = cap_rw_q;
    cap_m2r_d   = cap_m2r_q;
    cap_wreg_d  = cap_wreg_q;
    cap_alu_d   = cap_alu_q;
    cap_pc_d    = cap_pc_q;
    cap_instr_d = cap_instr_q;
    rdata_d     = rdata_q;
    wb_rw_d     = 1'b0;
    wb_wreg_d   = wb_wreg_q;
    wb_res_d    = wb_res_q;
    wb_pc_d     = wb_pc_q;
    wb_instr_d  = wb_instr_q;
    align_d     = 1'b0;
    berr_d      = 1'b0;
    ctr_clr     = 1'b0;
    ctr_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ctr_clr = 1'b1;
        if (!access) begin
          wb_rw_d    = MEM_RegWrite;
          wb_wreg_d  = MEM_WriteReg;
          wb_res_d   = MEM_AluResult;
          wb_pc_d    = MEM_PC;
          wb_instr_d = MEM_Instr;
        end else if (misal) begin
          align_d = 1'b1;
        end else begin
          state_d     = ST_BUSY;
          req_d       = 1'b1;
          we_d        = MEM_MemWrite;
          addr_d      = MEM_AluResult;
          wdata_d     = MEM_WriteData;
          cap_rw_d    = MEM_RegWrite;
          cap_m2r_d   = MEM_MemToReg;
          cap_wreg_d  = MEM_WriteReg;
          cap_alu_d   = MEM_AluResult;
          cap_pc_d    = MEM_PC;
          cap_instr_d = MEM_Instr;
        end
      end
      ST_BUSY: begin
        if (dmem.dmem_ack) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          rdata_d = dmem.dmem_rdata;
        end else if (ctr_expire) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          berr_d  = 1'b1;
        end else begin
          ctr_en = 1'b1;
        end
      end
      ST_DONE: begin
        // bus_err is still high in DONE after a timeout, which squashes the write.
        state_d    = ST_IDLE;
        wb_rw_d    = cap_rw_q & !berr_q;
        wb_wreg_d  = cap_wreg_q;
        wb_res_d   = cap_m2r_q ? rdata_q : cap_alu_q;
        wb_pc_d    = cap_pc_q;
        wb_instr_d = cap_instr_q;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cap_rw_q    <= 1'b0;
      cap_m2r_q   <= 1'b0;
      cap_wreg_q  <= '0;
      cap_alu_q   <= '0;
      cap_pc_q    <= '0;
      cap_instr_q <= '0;
      rdata_q     <= '0;
      wb_rw_q     <= 1'b0;
      wb_wreg_q   <= '0;
      wb_res_q    <= '0;
      wb_pc_q     <= '0;
      wb_instr_q  <= '0;
      align_q     <= 1'b0;
      berr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cap_rw_q    <= cap_rw_d;
      cap_m2r_q   <= cap_m2r_d;
      cap_wreg_q  <= cap_wreg_d;
      cap_alu_q   <= cap_alu_d;
      cap_pc_q    <= cap_pc_d;
      cap_instr_q <= cap_instr_d;
      rdata_q     <= rdata_d;
      wb_rw_q     <= wb_rw_d;
      wb_wreg_q   <= wb_wreg_d;
      wb_res_q    <= wb_res_d;
      wb_pc_q     <= wb_pc_d;
      wb_instr_q  <= wb_instr_d;
      align_q     <= align_d;
      berr_q      <= berr_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  assign WB_RegWrite = wb_rw_q;
  assign WB_WriteReg = wb_wreg_q;
  assign WB_Result   = wb_res_q;
  assign WB_PC       = wb_pc_q;
  assign WB_Instr    = wb_instr_q;
  assign align_err   = align_q;
  assign bus_err     = berr_q;

endmodule
